// File: rtl/piano_synth.sv
// Single-voice square-wave piano tone generator: key priority, per-key half-period table,
// octave shift, live and one-shot play modes.
module piano_synth #(
    parameter int NUM_KEYS = 8,
    parameter int DIV_W = 18,
    parameter logic [NUM_KEYS*DIV_W-1:0] HALF_PERIODS = {
        18'd191110, 18'd170265, 18'd151685, 18'd143172,
        18'd127551, 18'd113636, 18'd101239, 18'd95556
    },
    parameter int NOTE_CYCLES = 25_000_000,
    parameter int NOTE_W = 25
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NUM_KEYS-1:0] sw,
    input  logic [1:0]          octave,
    input  logic                mode,
    output logic                FREQ,
    output logic [NUM_KEYS-1:0] Led,
    output logic                busy
);

    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LIVE,
        SHOT,
        WAITREL
    } state_t;

    state_t              state_reg;
    logic [KW-1:0]       key_reg;
    logic [DIV_W-1:0]    cnt_reg;
    logic [NOTE_W-1:0]   timer_reg;

    logic [DIV_W-1:0]    half_tab [NUM_KEYS];
    logic [NUM_KEYS-1:0] pri_onehot;
    logic [KW-1:0]       pri;
    logic                any_key;
    logic [DIV_W-1:0]    shifted;
    logic [DIV_W-1:0]    eff;
    logic                tone_wrap;

    // Unpack the table; a key wins only if no higher-index (lower-pitch) key is held.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            assign half_tab[gi] = HALF_PERIODS[gi*DIV_W +: DIV_W];
            if (gi == NUM_KEYS - 1) begin : g_top
                assign pri_onehot[gi] = sw[gi];
            end else begin : g_low
                assign pri_onehot[gi] = sw[gi] & ~(|sw[NUM_KEYS-1:gi+1]);
            end
        end
    endgenerate

    always_comb begin
        pri = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (pri_onehot[i]) begin
                pri = KW'(i);
            end
        end
    end

    assign any_key = |sw;
    assign shifted = half_tab[key_reg] >> octave;
    assign eff     = (shifted == '0) ? DIV_W'(1) : shifted;
    // >= rather than == so a mid-note octave change never lets the counter run away.
    assign tone_wrap = (cnt_reg >= (eff - DIV_W'(1)));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
            key_reg   <= '0;
            cnt_reg   <= '0;
            timer_reg <= '0;
            FREQ      <= 1'b0;
            Led       <= '0;
            busy      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    FREQ <= 1'b0;
                    if (any_key) begin
                        key_reg <= pri;
                        cnt_reg <= '0;
                        Led     <= pri_onehot;
                        busy    <= 1'b1;
                        if (mode) begin
                            state_reg <= SHOT;
                            timer_reg <= NOTE_W'(NOTE_CYCLES - 1);
                        end else begin
                            state_reg <= LIVE;
                        end
                    end
                end
                LIVE: begin
                    if (!any_key) begin
                        state_reg <= IDLE;
                        FREQ      <= 1'b0;
                        cnt_reg   <= '0;
                        Led       <= '0;
                        busy      <= 1'b0;
                    end else if (pri != key_reg) begin
                        // Phase restarts on the new key but the output level is held.
                        key_reg <= pri;
                        cnt_reg <= '0;
                        Led     <= pri_onehot;
                    end else if (tone_wrap) begin
                        cnt_reg <= '0;
                        FREQ    <= ~FREQ;
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end
                SHOT: begin
                    if (timer_reg == '0) begin
                        FREQ      <= 1'b0;
                        cnt_reg   <= '0;
                        Led       <= '0;
                        busy      <= 1'b0;
                        state_reg <= any_key ? WAITREL : IDLE;
                    end else begin
                        timer_reg <= timer_reg - NOTE_W'(1);
                        if (tone_wrap) begin
                            cnt_reg <= '0;
                            FREQ    <= ~FREQ;
                        end else begin
                            cnt_reg <= cnt_reg + DIV_W'(1);
                        end
                    end
                end
                WAITREL: begin
                    FREQ <= 1'b0;
                    if (!any_key) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    FREQ      <= 1'b0;
                    Led       <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piano_synth.sv
// Bench for piano_synth: directed scenario tasks plus a randomized run against a
// timestamp-based behavioural model.
module tb_piano_synth;

    localparam int NK = 8;
    localparam int DW = 18;
    localparam int NC = 20;

    logic          CLK;
    logic          RESET;
    logic [NK-1:0] sw;
    logic [1:0]    octave;
    logic          mode;
    logic          FREQ;
    logic [NK-1:0] Led;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    piano_synth #(
        .NUM_KEYS(NK),
        .DIV_W(DW),
        .HALF_PERIODS({18'd11, 18'd10, 18'd9, 18'd8, 18'd7, 18'd6, 18'd5, 18'd4}),
        .NOTE_CYCLES(NC),
        .NOTE_W(25)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .sw(sw),
        .octave(octave),
        .mode(mode),
        .FREQ(FREQ),
        .Led(Led),
        .busy(busy)
    );

    initial begin
        CLK = 1'b0;
        forever #1 CLK = ~CLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Half-period from the spec rule: (4+k) >> octave, clamped to at least 1.
    function automatic int eff_of(int k, int o);
        int h;
        h = (4 + k) >> o;
        return (h == 0) ? 1 : h;
    endfunction

    function automatic int pri_of(logic [NK-1:0] s);
        int r;
        r = -1;
        for (int i = 0; i < NK; i++) if (s[i]) r = i;
        return r;
    endfunction

    // Behavioural model: phase is the edge number of the last toggle / phase restart.
    int   m_state;   // 0 idle, 1 live, 2 shot, 3 waiting for release
    int   m_key;
    int   m_phase;
    int   m_end;
    int   m_n;
    logic m_freq;

    task automatic model_step();
        int p;
        m_n++;
        p = pri_of(sw);
        if (RESET) begin
            m_state = 0;
            m_freq  = 1'b0;
        end else begin
            case (m_state)
                0: if (p >= 0) begin
                    m_key   = p;
                    m_phase = m_n;
                    m_freq  = 1'b0;
                    if (mode) begin
                        m_state = 2;
                        m_end   = m_n + NC;
                    end else begin
                        m_state = 1;
                    end
                end
                1: if (p < 0) begin
                    m_state = 0;
                    m_freq  = 1'b0;
                end else if (p != m_key) begin
                    m_key   = p;
                    m_phase = m_n;
                end else if (m_n - m_phase >= eff_of(m_key, int'(octave))) begin
                    m_freq  = ~m_freq;
                    m_phase = m_n;
                end
                2: if (m_n == m_end) begin
                    m_freq  = 1'b0;
                    m_state = (p >= 0) ? 3 : 0;
                end else if (m_n - m_phase >= eff_of(m_key, int'(octave))) begin
                    m_freq  = ~m_freq;
                    m_phase = m_n;
                end
                default: if (p < 0) m_state = 0;
            endcase
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET = 1'b1; sw = 8'h20; mode = 1'b0; octave = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (FREQ !== 1'b0 || Led !== 8'h00 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got FREQ=%b Led=%h busy=%b, required 0/00/0", i, FREQ, Led, busy);
            end
        end
        RESET = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (Led !== 8'h20 || busy !== 1'b1 || FREQ !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got FREQ=%b Led=%h busy=%b, required 0/20/1", FREQ, Led, busy);
        end
        $display("test_reset done");
    endtask

    // Continues from test_reset: key 5 is already sounding, entered on the last edge.
    task automatic test_live();
        for (int j = 1; j <= 36; j++) begin
            @(negedge CLK);
            n_cmp++;
            if (FREQ !== 1'(((j / 9) % 2))) begin
                n_bad++;
                $display("FAIL live_k5[%0d]: got FREQ=%b, required %0d", j, FREQ, (j / 9) % 2);
            end
        end
        sw = 8'h00;
        @(negedge CLK);
        n_cmp++;
        if (FREQ !== 1'b0 || Led !== 8'h00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL live_release: got FREQ=%b Led=%h busy=%b, required 0/00/0", FREQ, Led, busy);
        end
        $display("test_live done");
    endtask

    task automatic test_priority();
        sw = 8'h28;
        @(negedge CLK);
        n_cmp++;
        if (Led !== 8'h20 || FREQ !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_entry: got Led=%h FREQ=%b, required 20/0", Led, FREQ);
        end
        for (int j = 1; j <= 12; j++) begin
            @(negedge CLK);
            n_cmp++;
            if (FREQ !== 1'(((j / 9) % 2)) || Led !== 8'h20) begin
                n_bad++;
                $display("FAIL prio_k5[%0d]: got FREQ=%b Led=%h, required %0d/20", j, FREQ, Led, (j / 9) % 2);
            end
        end
        sw = 8'h08;
        @(negedge CLK);
        n_cmp++;
        if (Led !== 8'h08 || FREQ !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_change: got Led=%h FREQ=%b, required 08/1", Led, FREQ);
        end
        for (int j = 1; j <= 28; j++) begin
            @(negedge CLK);
            n_cmp++;
            if (FREQ !== 1'(1 - ((j / 7) % 2))) begin
                n_bad++;
                $display("FAIL prio_k3[%0d]: got FREQ=%b, required %0d", j, FREQ, 1 - ((j / 7) % 2));
            end
        end
        sw = 8'h00;
        @(negedge CLK);
        $display("test_priority done");
    endtask

    task automatic test_octave_clamp();
        logic [NK-1:0] keys [3] = '{8'h80, 8'h80, 8'h01};
        int            octs [3] = '{1, 3, 3};
        int            effs [3] = '{5, 1, 1};
        for (int t = 0; t < 3; t++) begin
            sw = keys[t];
            octave = 2'(octs[t]);
            @(negedge CLK);
            n_cmp++;
            if (Led !== keys[t] || FREQ !== 1'b0) begin
                n_bad++;
                $display("FAIL oct_entry[%0d]: got Led=%h FREQ=%b, required %h/0", t, Led, FREQ, keys[t]);
            end
            for (int j = 1; j <= 20; j++) begin
                @(negedge CLK);
                n_cmp++;
                if (FREQ !== 1'(((j / effs[t]) % 2))) begin
                    n_bad++;
                    $display("FAIL oct[%0d][%0d]: got FREQ=%b, required %0d", t, j, FREQ, (j / effs[t]) % 2);
                end
            end
            sw = 8'h00;
            @(negedge CLK);
        end
        octave = 2'd0;
        $display("test_octave_clamp done");
    endtask

    task automatic test_one_shot();
        int busy_cnt;
        mode = 1'b1;
        sw = 8'h40;
        @(negedge CLK);
        sw = 8'h00;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        n_cmp++;
        if (Led !== 8'h40 || busy !== 1'b1 || FREQ !== 1'b0) begin
            n_bad++;
            $display("FAIL shot_entry: got Led=%h busy=%b FREQ=%b, required 40/1/0", Led, busy, FREQ);
        end
        for (int j = 1; j <= 25; j++) begin
            @(negedge CLK);
            if (busy === 1'b1) busy_cnt++;
            n_cmp++;
            if (j < NC) begin
                if (FREQ !== 1'(((j / 10) % 2)) || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL shot_k6[%0d]: got FREQ=%b busy=%b, required %0d/1", j, FREQ, busy, (j / 10) % 2);
                end
            end else if (FREQ !== 1'b0 || busy !== 1'b0 || Led !== 8'h00) begin
                n_bad++;
                $display("FAIL shot_end[%0d]: got FREQ=%b busy=%b Led=%h, required 0/0/00", j, FREQ, busy, Led);
            end
        end
        n_cmp++;
        if (busy_cnt != NC) begin
            n_bad++;
            $display("FAIL shot_len: got %0d busy cycles, required %0d", busy_cnt, NC);
        end
        $display("test_one_shot done");
    endtask

    task automatic test_waitrel();
        mode = 1'b1;
        sw = 8'h04;
        for (int j = 0; j <= NC; j++) @(negedge CLK);
        for (int j = 0; j < 10; j++) begin
            n_cmp++;
            if (busy !== 1'b0 || FREQ !== 1'b0 || Led !== 8'h00) begin
                n_bad++;
                $display("FAIL waitrel_hold[%0d]: got busy=%b FREQ=%b Led=%h, required 0/0/00", j, busy, FREQ, Led);
            end
            @(negedge CLK);
        end
        sw = 8'h00;
        @(negedge CLK);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL waitrel_release: got busy=%b, required 0", busy);
        end
        sw = 8'h04;
        @(negedge CLK);
        n_cmp++;
        if (busy !== 1'b1 || Led !== 8'h04) begin
            n_bad++;
            $display("FAIL waitrel_retrig: got busy=%b Led=%h, required 1/04", busy, Led);
        end
        sw = 8'h00;
        for (int j = 0; j < NC + 2; j++) @(negedge CLK);
        $display("test_waitrel done");
    endtask

    task automatic test_mid_reset();
        mode = 1'b1;
        sw = 8'h01;
        @(negedge CLK);
        sw = 8'h00;
        for (int j = 1; j <= 5; j++) @(negedge CLK);
        n_cmp++;
        if (FREQ !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_pre: got FREQ=%b busy=%b, required 1/1", FREQ, busy);
        end
        RESET = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (FREQ !== 1'b0 || busy !== 1'b0 || Led !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst: got FREQ=%b busy=%b Led=%h, required 0/0/00", FREQ, busy, Led);
        end
        RESET = 1'b0;
        mode = 1'b0;
        @(negedge CLK);
        $display("test_mid_reset done");
    endtask

    task automatic test_random();
        logic [NK-1:0] one;
        logic [NK-1:0] exp_led;
        logic          exp_busy;
        int            r;
        one = 8'h01;
        RESET = 1'b1;
        sw = 8'h00;
        @(posedge CLK);
        model_step();
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            exp_busy = (m_state == 1 || m_state == 2);
            exp_led  = exp_busy ? (one << m_key) : 8'h00;
            n_cmp++;
            if (FREQ !== m_freq) begin
                n_bad++;
                $display("FAIL rnd_freq[%0d]: got %b, required %b", i, FREQ, m_freq);
            end
            n_cmp++;
            if (Led !== exp_led) begin
                n_bad++;
                $display("FAIL rnd_led[%0d]: got %h, required %h", i, Led, exp_led);
            end
            n_cmp++;
            if (busy !== exp_busy) begin
                n_bad++;
                $display("FAIL rnd_busy[%0d]: got %b, required %b", i, busy, exp_busy);
            end
            RESET = ($urandom_range(0, 299) == 0);
            r = int'($urandom_range(0, 15));
            if (r == 0) sw = 8'h00;
            else if (r == 1) sw = 8'($urandom);
            else if (r == 2) sw = one << $urandom_range(0, 7);
            if ($urandom_range(0, 39) == 0) octave = 2'($urandom);
            if ($urandom_range(0, 9) == 0) mode = 1'($urandom);
            @(posedge CLK);
            model_step();
        end
        RESET = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        RESET = 1'b1;
        sw = 8'h00;
        octave = 2'd0;
        mode = 1'b0;
        m_state = 0; m_key = 0; m_phase = 0; m_end = 0; m_n = 0; m_freq = 1'b0;
        test_reset();
        test_live();
        test_priority();
        test_octave_clamp();
        test_one_shot();
        test_waitrel();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/piano_synth.md
# piano_synth

Parametrised single-voice piano tone generator for the FPGA piano. It maps a bank of NUM_KEYS key switches to square-wave tones through a per-key half-period table, octave shift and key priority. Two play modes are supported: live, where the tone lasts while the key is held, and one-shot, where each key press plays a note of fixed length. It sits between the board switches and the speaker pin, and drives the LEDs with the sounding key.

## Interface
- NUM_KEYS, 8: number of key switches. Bit NUM_KEYS-1 is the lowest pitch (C4); bit 0 is the highest (C5 at the default).
- DIV_W, 18: width of each half-period entry and of the tone counter.
- HALF_PERIODS, {191110,170265,151685,143172,127551,113636,101239,95556} packed MSB-first: flat NUM_KEYS*DIV_W vector. Entry k is bits [k*DIV_W +: DIV_W] and gives the half-period of key k in CLK cycles at 100 MHz.
- NOTE_CYCLES, 25_000_000: one-shot note length in CLK cycles. Must be ≥1.
- NOTE_W, 25: width of the note-length timer.
- CLK in 1: system clock. All logic is on the rising edge.
- RESET in 1: reset, synchronous and active-high.
- sw in NUM_KEYS: key switches, level-sensitive, already synchronised.
- octave in 2: octave-up shift, 0–3.
- mode in 1: 0 = live, 1 = one-shot. Sampled only in IDLE.
- FREQ out 1: square-wave tone output.
- Led out NUM_KEYS: one-hot indicator of the sounding key.
- busy out 1: high while a note sounds.

## Operation
- Priority: the selected key k is the highest-index set bit of sw (lowest pitch wins).
- Effective half-period: eff = HALF_PERIODS[k] >> octave. If the result is 0, clamp eff to 1.
- States:
  - IDLE: nothing sounds.
  - LIVE: tone follows the held key.
  - SHOT: fixed-length note is playing.
  - WAITREL: note finished, waiting for all keys to be released.
- IDLE:
  - If sw≠0 and mode=0: go to LIVE.
  - If sw≠0 and mode=1: go to SHOT and load the timer with NOTE_CYCLES-1.
  - On entry to either state: latch key k; cnt←0; FREQ←0.
- Tone counter (LIVE and SHOT), on each edge:
  - If cnt ≥ eff-1: cnt←0 and FREQ←~FREQ.
  - Otherwise: cnt←cnt+1.
  - Using ≥ keeps the counter correct when octave changes mid-note.
- LIVE:
  - sw=0: go to IDLE; FREQ←0; cnt←0.
  - Priority key changes to k'≠k: latch k'; cnt←0; FREQ keeps its level.
  - Changes to mode are ignored.
- SHOT:
  - Key is latched; sw and mode are ignored.
  - Timer decrements each edge. Edge with timer=0: FREQ←0; go to WAITREL if sw≠0, else IDLE.
- WAITREL: FREQ=0. Go to IDLE on the first edge with sw=0. No retrigger is possible while any key is held.
- Outputs:
  - Led = one-hot of the latched key in LIVE and SHOT; 0 otherwise.
  - busy = 1 in LIVE and SHOT; 0 otherwise.
  - All outputs are registered.

## Timing
- Reset on the edge where RESET=1: state IDLE, FREQ=0, Led=0, busy=0, cnt=0, timer=0. RESET overrides all other inputs, including mid-note.
- Key-to-output latency: sw sampled nonzero at edge t0 → Led and busy valid after t0, FREQ=0. The first FREQ rise occurs at edge t0+eff.
- Tone period is 2·eff cycles with 50% duty. A key change at edge t restarts the phase: the next toggle is at t+eff.
- Release latency (LIVE): sw=0 at edge t → FREQ, Led and busy are all 0 after t.
- SHOT duration: busy is high for exactly NOTE_CYCLES cycles.
- NOTE_CYCLES=1: a one-cycle note; FREQ never rises if eff>1.
- Octave change takes effect on the next counter compare. There is no glitch shorter than 1 cycle.

## Test plan
Bench parameters: NUM_KEYS=8, HALF_PERIODS entry k = 4+k (so key7=11, key5=9, key3=7, key0=4), NOTE_CYCLES=20. CLK period 2 ns.
- Reset: RESET=1 for 5 edges with sw=8'h20 → FREQ=0, Led=0, busy=0 throughout. On the first edge after RESET drops → Led=8'h20, busy=1.
- Live key 5: sw=8'h20, octave=0 → FREQ toggles every 9 edges (period 18). sw=0 → FREQ=0 and Led=0 one edge later.
- Priority and key change: sw=8'h28 → Led=8'h20, period 18. Clear bit 5 → Led=8'h08, phase restart, period 14.
- Octave and clamp:
  - Key 7, octave=1 → period 10; octave=3 → period 2.
  - Key 0 (HP=4), octave=3 → eff clamped to 1, period 2.
- One-shot: mode=1, key 6 pulsed for 1 cycle → busy high for exactly 20 edges, FREQ period 20, then FREQ=0.
- One-shot while held and mid-note reset:
  - Key held through note end → WAITREL, no retrigger until sw=0 for one edge, then a new press plays.
  - RESET asserted at note cycle 7 → all outputs 0 on that edge.
